bp_ctr_table: RTL
=================

// Module: bp_ctr_table
// PURPOSE
// - Multi-read-port table of saturating branch counters. Next generation of the
//   fetch-stage prediction RAM.
// - Adds: parametrised read ports and counter width, and an internal
//   read-modify-write update pipe (caller sends taken/not-taken, not raw data).
// - Adds: a post-reset init sweep, so large tables need no per-entry reset flops.
// - Sits between fetch (predict reads) and the branch-resolution path (updates).
// PARAMETERS
// - RPORT     4     number of independent combinational read ports
// - DEPTH     1024  number of counters; must equal 2**INDEX
// - INDEX     10    address width
// - CTR_BITS  2     counter width, 1..4
// - INIT_VAL  2     value written to every entry by the init sweep (weakly taken)
// PORTS
// - clk         in   1               clock, all state on posedge
// - reset       in   1               asynchronous, active-high
// - ready_o     out  1               1 = init sweep done, table in RUN
// - rd_addr_i   in   RPORT*INDEX     read index, port p at [p*INDEX +: INDEX]
// - rd_ctr_o    out  RPORT*CTR_BITS  counter value per port
// - rd_taken_o  out  RPORT           prediction per port = MSB of rd_ctr_o slice
// - upd_valid_i in   1               update request strobe
// - upd_addr_i  in   INDEX           index to update
// - upd_taken_i in   1               resolved direction
// BEHAVIOUR
// - Reset (async): state=INIT, sweep ptr=0, update pipe valid=0, ready_o=0.
//   - Array contents are NOT cleared by reset; the sweep rewrites them.
// - FSM INIT: each cycle writes INIT_VAL to entry ptr, then ptr++.
//   - At ptr==DEPTH-1, that write completes and state goes to RUN next cycle.
//   - INIT lasts exactly DEPTH cycles; ready_o=1 from the first RUN cycle.
// - FSM RUN: terminal state; only reset leaves it.
// - Reads: combinational, every port every cycle, independent of the others.
//   - During INIT all rd_ctr_o = INIT_VAL regardless of array contents.
// - Update pipe, 2 stages:
//   - S0: upd_* registered into S1 when upd_valid_i && state==RUN.
//     upd_valid_i during INIT is dropped silently.
//   - S1: old=array[S1.addr].
//     new = taken ? min(old+1, 2**CTR_BITS-1) : max(old-1, 0).
//     new written at end of S1 cycle.
//   - Latency: request in cycle N -> array holds new value from cycle N+2.
// - Boundary cases:
//   - Saturation: max stays max on taken; 0 stays 0 on not-taken; never wraps.
//   - Back-to-back updates to the same index: S1 uses the value being written
//     this cycle (internal forward), so two takens from 0 give 2, never 1.
//   - Updates to different indices are fully pipelined, one per cycle, no stall.
//   - Reset asserted mid-update: in-flight S1 write is discarded, sweep restarts
//     at 0.
//   - Any number of read ports may alias each other or the update index.
// - No backpressure: updates are always accepted in RUN.
// CONFIGURATION
// - BP_CTR_BYPASS_EN defined:
//   - A read whose index equals the S1 index while S1 is valid returns the new
//     (post-update) value in that same cycle.
// - BP_CTR_BYPASS_EN undefined:
//   - Reads return the array content, i.e. the old value.
//   - The new value becomes visible the following cycle.
// TESTING
// - Reset, then hold: ready_o=0 for exactly DEPTH cycles, then 1.
//   All reads = INIT_VAL throughout.
// - After ready: update idx 5 taken twice (2 cycles apart). Reads give 3; a
//   third taken still gives 3. Four not-takens give 0, a fifth still gives 0.
// - Back-to-back taken, taken on idx 7 in consecutive cycles from value 0
//   (CTR_BITS=2): final value 2.
// - upd_valid_i=1 on idx 9 during INIT: after ready, idx 9 reads INIT_VAL.
// - Read idx 3 on all RPORT ports while S1 updates idx 3 from 2 to 3:
//   - with BP_CTR_BYPASS_EN: all ports return 3 that cycle;
//   - without: all ports return 2 that cycle and 3 the next cycle.
// - Assert reset mid-sweep (ptr=100) and mid-update: ready_o drops
//   immediately. Sweep restarts, lasts DEPTH cycles. Updated entry reads INIT_VAL.

Source files
------------

// File: rtl/bp_ctr_table_if.sv
// bp_ctr_table_if: predict-read and branch-update bundle for bp_ctr_table.
interface bp_ctr_table_if #(
  parameter int RPORT    = 4,
  parameter int INDEX    = 10,
  parameter int CTR_BITS = 2
);
  logic                      ready_o;
  logic [RPORT*INDEX-1:0]    rd_addr_i;
  logic [RPORT*CTR_BITS-1:0] rd_ctr_o;
  logic [RPORT-1:0]          rd_taken_o;
  logic                      upd_valid_i;
  logic [INDEX-1:0]          upd_addr_i;
  logic                      upd_taken_i;
  modport slave (
    output ready_o, rd_ctr_o, rd_taken_o,
    input  rd_addr_i, upd_valid_i, upd_addr_i, upd_taken_i
  );
  modport master (
    input  ready_o, rd_ctr_o, rd_taken_o,
    output rd_addr_i, upd_valid_i, upd_addr_i, upd_taken_i
  );
endinterface

// File: rtl/bp_ctr_table.sv
// bp_ctr_table: multi-port saturating branch counter table with init sweep and RMW update pipe.
// Optional BP_CTR_BYPASS_EN: reads hitting the in-flight update index see the new value.
module bp_ctr_table #(
  parameter int RPORT    = 4,
  parameter int DEPTH    = 1024,
  parameter int INDEX    = 10,
  parameter int CTR_BITS = 2,
  parameter int INIT_VAL = 2
) (
  input logic           clk,
  input logic           reset,
  bp_ctr_table_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [CTR_BITS-1:0] INIT_C = CTR_BITS'(INIT_VAL);
  state_t               state_q, state_d;
  logic [INDEX-1:0]     ptr_q, ptr_d;
  logic                 s1_v_q, s1_v_d;
  logic [INDEX-1:0]     s1_a_q, s1_a_d;
  logic                 s1_t_q, s1_t_d;
  logic [CTR_BITS-1:0]  mem_q [DEPTH];
  logic [CTR_BITS-1:0]  old_ctr, new_ctr, wd;
  logic [INDEX-1:0]     wa;
  logic                 we;
  always_comb begin
    state_d = (state_q == INIT && &ptr_q) ? RUN : state_q;
    ptr_d   = state_q == INIT ? ptr_q + 1'b1 : ptr_q;
    s1_v_d  = bus.upd_valid_i && state_q == RUN;
    s1_a_d  = bus.upd_addr_i;
    s1_t_d  = bus.upd_taken_i;
    old_ctr = mem_q[s1_a_q];
    new_ctr = s1_t_q ? (&old_ctr ? old_ctr : old_ctr + 1'b1)
                     : (~|old_ctr ? old_ctr : old_ctr - 1'b1);
    we      = state_q == INIT || s1_v_q;
    wa      = state_q == INIT ? ptr_q : s1_a_q;
    wd      = state_q == INIT ? INIT_C : new_ctr;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_t_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_t_q  <= s1_t_d;
    end
  end
  // Table body carries no reset; the sweep rewrites every entry after reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end
  assign bus.ready_o = state_q == RUN;
  for (genvar p = 0; p < RPORT; p++) begin : g_rd
    logic [INDEX-1:0]    a;
    logic [CTR_BITS-1:0] c;
    assign a = bus.rd_addr_i[p*INDEX +: INDEX];
`ifdef BP_CTR_BYPASS_EN
    assign c = state_q == INIT ? INIT_C : (s1_v_q && a == s1_a_q) ? new_ctr : mem_q[a];
`else
    assign c = state_q == INIT ? INIT_C : mem_q[a];
`endif
    assign bus.rd_ctr_o[p*CTR_BITS +: CTR_BITS] = c;
    assign bus.rd_taken_o[p] = c[CTR_BITS-1];
  end
endmodule
